alu_result_stage: RTL and testbench

- Downstream stage of the 16-bit combinational ALU. Captures each ALU result with its operands, opcode and tag under a valid/ready handshake.
- Computes status flags (overflow pair, zero, illegal-op error) and buffers entries in a small in-order FIFO.
- Presents entries to the writeback/consumer side. Decouples ALU timing from consumer back-pressure.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_flag_calc.sv | 51 +++++
 rtl/alu_result_stage.sv | 137 +++++++++++++
 tb/tb_alu_result_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage.
//   op_e       : ALU opcode encoding (OP_ILL marks the unused, illegal opcode)
//   OVF_U/OVF_S: bit positions inside the 2-bit overflow flag field
//   flag_res_t : flag calculator output (possibly forced result plus status)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_MUL = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_NOT = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  localparam int OVF_U = 0;  // unsigned carry / borrow / overflow
  localparam int OVF_S = 1;  // signed overflow

  typedef struct packed {
    logic [31:0] result;
    logic [1:0]  ovf;
    logic        zero;
    logic        err;
  } flag_res_t;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational status-flag calculator for one ALU transaction.
//   in_opcode, in_a, in_b, in_result : ALU opcode, operands and raw result
//   flags                            : result to store (forced to 0 for the
//                                      illegal opcode), overflow pair, zero, err
module alu_flag_calc
  import alu_pkg::*;
(
  input  logic [2:0]  in_opcode,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [31:0] in_result,
  output flag_res_t   flags
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    flags        = '0;
    flags.result = in_result;

    unique case (op_e'(in_opcode))
      OP_ADD: begin
        flags.ovf[OVF_U] = in_result[16];
        flags.ovf[OVF_S] = (in_a[15] == in_b[15]) && (in_result[15] != in_a[15]);
      end
      OP_MUL: begin
        // Unsigned multiply: anything in the upper half means the 16-bit
        // product overflowed; there is no signed interpretation.
        flags.ovf[OVF_U] = |in_result[31:16];
      end
      OP_SUB: begin
        flags.ovf[OVF_U] = (in_a < in_b);
        flags.ovf[OVF_S] = (in_a[15] != in_b[15]) && (in_result[15] != in_a[15]);
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        flags.ovf = 2'b00;
      end
      OP_ILL: begin
        flags.result = '0;
        flags.err    = 1'b1;
      end
      default: begin
        flags.ovf = 2'b00;
      end
    endcase

    // Zero is judged on the value actually stored, i.e. after forcing.
    flags.zero = (flags.result == '0);
  end

endmodule

// File: rtl/alu_result_stage.sv
// Result stage behind the 16-bit ALU: captures result, tag and computed
// status flags into an in-order FIFO and presents the head to the consumer.
//   in_valid/in_ready   : upstream handshake; inputs sampled only on push
//   in_opcode/a/b       : ALU opcode and operands (used for flag derivation)
//   in_result, in_tag   : ALU result and transaction tag
//   out_valid/out_ready : consumer handshake for the head entry
//   out_result/tag/...  : head entry fields, all zero while the FIFO is empty
//   count               : current occupancy
//   err_cnt             : saturating count of accepted illegal opcodes
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [15:0]              in_a,
  input  logic [15:0]              in_b,
  input  logic [31:0]              in_result,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [1:0]               out_overflow_flag,
  output logic                     out_zero,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic [1:0]       ovf;
    logic             zero;
    logic             err;
  } entry_t;

  entry_t                 mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  flag_res_t flags;
  entry_t    new_entry;
  entry_t    head;
  logic      push, pop;

  alu_flag_calc u_flag_calc (
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_result (in_result),
    .flags     (flags)
  );

  // A full FIFO refuses input even when the head is being popped this cycle;
  // this keeps in_ready independent of out_ready.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_entry        = '0;
    new_entry.result = flags.result;
    new_entry.tag    = in_tag;
    new_entry.ovf    = flags.ovf;
    new_entry.zero   = flags.zero;
    new_entry.err    = flags.err;
  end

  // Pointers are PTR_W wide with DEPTH a power of two, so +1 wraps naturally.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push && flags.err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; clearing count and
  // pointers already makes every stale entry invisible, and the outputs below
  // are gated to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head              = mem_q[rd_ptr_q];
  assign out_result        = out_valid ? head.result : '0;
  assign out_tag           = out_valid ? head.tag    : '0;
  assign out_overflow_flag = out_valid ? head.ovf    : '0;
  assign out_zero          = out_valid ? head.zero   : 1'b0;
  assign out_err           = out_valid ? head.err    : 1'b0;
  assign count             = count_q;
  assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: a vector table of hand-derived
// expected entries, a scoreboard queue filled on push and drained on pop,
// plus directed sequences for full-FIFO, saturation and mid-stream reset.
module tb_alu_result_stage;

  localparam int DEPTH     = 4;
  localparam int TAG_W     = 4;
  localparam int ERR_CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [15:0]       in_a, in_b;
  logic [31:0]       in_result;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        out_overflow_flag;
  logic              out_zero, out_err;
  logic [$clog2(DEPTH):0] count;
  logic [ERR_CNT_W-1:0]   err_cnt;

  alu_result_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_opcode         (in_opcode),
    .in_a              (in_a),
    .in_b              (in_b),
    .in_result         (in_result),
    .in_tag            (in_tag),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_tag           (out_tag),
    .out_overflow_flag (out_overflow_flag),
    .out_zero          (out_zero),
    .out_err           (out_err),
    .count             (count),
    .err_cnt           (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic [15:0]      a, b;
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_res;
    logic [1:0]       exp_ovf;
    logic             exp_zero;
    logic             exp_err;
  } vec_t;

  vec_t vecs [11];
  vec_t sb_q [$];
  vec_t cur;

  int checks = 0;
  int errors = 0;
  logic [ERR_CNT_W-1:0] exp_err_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid);
    cur       = v;
    in_valid  = valid;
    in_opcode = v.op;
    in_a      = v.a;
    in_b      = v.b;
    in_result = v.res;
    in_tag    = v.tag;
  endtask

  // Called at a negedge: compare what the coming posedge will pop, record
  // what it will push, then advance one cycle.
  task automatic step();
    vec_t e;
    check("count_vs_model", 32'(count), 32'(sb_q.size()));
    check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pop", 32'(out_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("out_result", out_result, e.exp_res);
        check("out_tag", 32'(out_tag), 32'(e.tag));
        check("out_ovf", 32'(out_overflow_flag), 32'(e.exp_ovf));
        check("out_zero", 32'(out_zero), 32'(e.exp_zero));
        check("out_err", 32'(out_err), 32'(e.exp_err));
      end
    end
    if (in_valid && in_ready) begin
      sb_q.push_back(cur);
      if (cur.exp_err && exp_err_cnt != '1) exp_err_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    vec_t idle;
    idle = '{default: '0};
    drive(idle, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 32 && sb_q.size() != 0; i++) step();
    check("drain_done", 32'(sb_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [31:0] res, input logic [TAG_W-1:0] tag,
                              input logic [31:0] er, input logic [1:0] eo,
                              input logic ez, input logic ee);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.tag = tag;
    v.exp_res = er; v.exp_ovf = eo; v.exp_zero = ez; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    vec_t v;
    //            op    a        b        result         tag   exp_res        ovf    z     e
    vecs[0]  = mk(3'd0, 16'hFFFF, 16'h0001, 32'h0001_0000, 4'h3, 32'h0001_0000, 2'b01, 1'b0, 1'b0);
    vecs[1]  = mk(3'd0, 16'h7FFF, 16'h0001, 32'h0000_8000, 4'h4, 32'h0000_8000, 2'b10, 1'b0, 1'b0);
    vecs[2]  = mk(3'd1, 16'h0100, 16'h0100, 32'h0001_0000, 4'h5, 32'h0001_0000, 2'b01, 1'b0, 1'b0);
    vecs[3]  = mk(3'd2, 16'h0001, 16'h0002, 32'h0000_FFFF, 4'h6, 32'h0000_FFFF, 2'b01, 1'b0, 1'b0);
    vecs[4]  = mk(3'd2, 16'h8000, 16'h0001, 32'h0000_7FFF, 4'h7, 32'h0000_7FFF, 2'b10, 1'b0, 1'b0);
    vecs[5]  = mk(3'd3, 16'h00FF, 16'hFF00, 32'h0000_0000, 4'h8, 32'h0000_0000, 2'b00, 1'b1, 1'b0);
    vecs[6]  = mk(3'd5, 16'h1200, 16'h0034, 32'h0000_1234, 4'h9, 32'h0000_1234, 2'b00, 1'b0, 1'b0);
    vecs[7]  = mk(3'd7, 16'h1111, 16'h2222, 32'h0000_1234, 4'hA, 32'h0000_0000, 2'b00, 1'b1, 1'b1);
    vecs[8]  = mk(3'd0, 16'h0000, 16'h0000, 32'h0000_0000, 4'hB, 32'h0000_0000, 2'b00, 1'b1, 1'b0);
    vecs[9]  = mk(3'd1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4'hC, 32'hFFFE_0001, 2'b01, 1'b0, 1'b0);
    vecs[10] = mk(3'd0, 16'h8000, 16'h8000, 32'h0001_0000, 4'hD, 32'h0001_0000, 2'b11, 1'b0, 1'b0);

    v = '{default: '0};
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(v, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset / idle state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_out_result", out_result, 32'd0);

    // One-cycle latency: push with consumer stalled, head visible next cycle
    drive(vecs[0], 1'b1);
    step();
    drive(v, 1'b0);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_tag", 32'(out_tag), 32'd3);
    check("lat_out_ovf", 32'(out_overflow_flag), 32'b01);
    check("lat_out_zero", 32'(out_zero), 32'd0);
    drain();

    // Vector table streamed back-to-back with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i], 1'b1);
      step();
    end
    drain();

    // Fill with the consumer stalled; the fifth push must be refused
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = mk(3'd3, 16'h0F0F, 16'h00FF, 32'h0000_000F, 4'(i), 32'h0000_000F, 2'b00, 1'b0, 1'b0);
      drive(v, 1'b1);
      step();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    // Release the consumer while upstream keeps offering; once in_ready
    // returns, push and pop coincide and occupancy stays at DEPTH-1.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = mk(3'd4, 16'h00F0, 16'h000F, 32'h0000_00FF, 4'(5 + i), 32'h0000_00FF, 2'b00, 1'b0, 1'b0);
      drive(v, 1'b1);
      step();
      if (i > 0) check("steady_count", 32'(count), 32'd3);
    end
    drain();

    // Illegal opcode repeated until the error counter saturates
    v = mk(3'd7, 16'h0001, 16'h0002, 32'h0000_1234, 4'h5, 32'h0000_0000, 2'b00, 1'b1, 1'b1);
    drive(v, 1'b1);
    for (int i = 0; i < 300; i++) step();
    drain();
    check("err_cnt_sat", 32'(err_cnt), 32'h0000_00FF);

    // Asynchronous reset with three entries buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = mk(3'd0, 16'h0001, 16'h0001, 32'h0000_0002, 4'(2 + i), 32'h0000_0002, 2'b00, 1'b0, 1'b0);
      drive(v, 1'b1);
      step();
    end
    drive(v, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    sb_q.delete();
    exp_err_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = mk(3'd2, 16'h0005, 16'h0003, 32'h0000_0002, 4'h9, 32'h0000_0002, 2'b00, 1'b0, 1'b0);
    drive(v, 1'b1);
    step();
    drive(v, 1'b0);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_tag", 32'(out_tag), 32'h9);
    check("post_rst_result", out_result, 32'h0000_0002);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so a stuck run still ends with a failure line.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
